// File: rtl/sram_phase_sequencer.sv
// sram_phase_sequencer
// Purpose : fast-domain SRAM sequencer. Turns one 32-bit request per
//           system-clock period into two back-to-back 16-bit SRAM accesses.
//           The low half is accessed first, then the high half. The result is
//           returned before the next system-clock edge.
// Latency : the request is launched at the edge that samples phase 0. The
//           completion (rsp_valid, rsp_rdata) is registered at the edge that
//           samples phase 6, so it is visible from phase 7 onward.
// Backpressure: none. Requests are accepted only at phase 0 while idle and
//           locked. At most one operation runs per system period.
// Ports   : modified_clock_sram/reset - clock and async active-high reset
//           dcm_locked, modified_clock_period - clock-manager lock and phase
//           req_* - system-side request; rsp_* - completion and read data
//           busy, sync_error - status (sync_error is sticky until reset)
//           sram_* - SRAM pad interface (active-low strobes, split data bus)

module sram_phase_sequencer #(
  parameter int RATIO      = 10,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  modified_clock_sram,
  input  logic                  reset,
  input  logic                  dcm_locked,
  input  logic [7:0]            modified_clock_period,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  busy,
  output logic                  sync_error,
  output logic [ADDR_WIDTH:0]   sram_addr,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [15:0]           sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [15:0]           sram_dq_in
);

  // The encoding of each active state equals the phase that the next edge
  // must sample while the FSM sits in that state. This makes the alignment
  // check a plain compare.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LO_SETUP  = 3'd1,
    ST_LO_STROBE = 3'd2,
    ST_LO_HOLD   = 3'd3,
    ST_HI_SETUP  = 3'd4,
    ST_HI_STROBE = 3'd5,
    ST_HI_HOLD   = 3'd6
  } state_e;

  localparam logic [7:0] LAST_PHASE = 8'(RATIO - 1);

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_hi_q, wdata_hi_d;
  logic [31:0]           temp_q, temp_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  busy_q, busy_d;
  logic                  sync_error_q, sync_error_d;
  logic [ADDR_WIDTH:0]   sram_addr_q, sram_addr_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic [15:0]           dq_out_q, dq_out_d;
  logic                  dq_oe_q, dq_oe_d;

  logic                  phase_zero;
  logic                  phase_ok;
  logic                  phase_out_of_range;

  assign phase_zero         = (modified_clock_period == 8'd0);
  assign phase_ok           = (modified_clock_period == {5'd0, state_q});
  // A phase beyond RATIO-1 means the clock manager and this block disagree
  // on the ratio. That is a misalignment even when no access is running.
  assign phase_out_of_range = (modified_clock_period > LAST_PHASE);

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_hi_d   = wdata_hi_q;
    temp_d       = temp_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    busy_d       = busy_q;
    sync_error_d = sync_error_q;
    sram_addr_d  = sram_addr_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    dq_out_d     = dq_out_q;
    dq_oe_d      = dq_oe_q;

    if (state_q == ST_IDLE) begin
      if (phase_zero) begin
        // The previous completion has been seen by the system edge by now.
        rsp_valid_d = 1'b0;
        if (req_valid && dcm_locked) begin
          state_d     = ST_LO_SETUP;
          wr_d        = req_write;
          addr_d      = req_addr;
          wdata_hi_d  = req_wdata[31:16];
          sram_addr_d = {req_addr, 1'b0};
          ce_n_d      = 1'b0;
          busy_d      = 1'b1;
          if (req_write) begin
            dq_oe_d  = 1'b1;
            dq_out_d = req_wdata[15:0];
          end else begin
            oe_n_d = 1'b0;
          end
        end
      end else if (phase_out_of_range) begin
        sync_error_d = 1'b1;
      end
    end else if (!dcm_locked || !phase_ok) begin
      // Abort overrides the normal step. A lost lock explains any phase
      // disturbance, so it does not raise sync_error.
      state_d = ST_IDLE;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      dq_oe_d = 1'b0;
      busy_d  = 1'b0;
      if (dcm_locked) begin
        sync_error_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_LO_SETUP: begin
          state_d = ST_LO_STROBE;
          if (wr_q) begin
            we_n_d = 1'b0;
          end
        end
        ST_LO_STROBE: begin
          state_d = ST_LO_HOLD;
          we_n_d  = 1'b1;
          if (!wr_q) begin
            temp_d[15:0] = sram_dq_in;
          end
        end
        ST_LO_HOLD: begin
          state_d     = ST_HI_SETUP;
          sram_addr_d = {addr_q, 1'b1};
          if (wr_q) begin
            dq_out_d = wdata_hi_q;
          end
        end
        ST_HI_SETUP: begin
          state_d = ST_HI_STROBE;
          if (wr_q) begin
            we_n_d = 1'b0;
          end
        end
        ST_HI_STROBE: begin
          state_d = ST_HI_HOLD;
          we_n_d  = 1'b1;
          if (!wr_q) begin
            temp_d[31:16] = sram_dq_in;
          end
        end
        ST_HI_HOLD: begin
          state_d     = ST_IDLE;
          ce_n_d      = 1'b1;
          oe_n_d      = 1'b1;
          dq_oe_d     = 1'b0;
          busy_d      = 1'b0;
          rsp_valid_d = 1'b1;
          if (!wr_q) begin
            rsp_rdata_d = temp_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge modified_clock_sram or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_hi_q   <= '0;
      temp_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      busy_q       <= 1'b0;
      sync_error_q <= 1'b0;
      sram_addr_q  <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_hi_q   <= wdata_hi_d;
      temp_q       <= temp_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      busy_q       <= busy_d;
      sync_error_q <= sync_error_d;
      sram_addr_q  <= sram_addr_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign busy        = busy_q;
  assign sync_error  = sync_error_q;
  assign sram_addr   = sram_addr_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// tb_sram_phase_sequencer
// Purpose : directed bench for sram_phase_sequencer. Expected responses are
//           queued at launch and compared by a separate monitor.
// Ports   : none (top-level bench).

module tb_sram_phase_sequencer;

  localparam int AW = 18;

  typedef struct packed {
    logic [AW:0] a;
    logic [15:0] d;
  } wev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dcm = 1'b1;
  logic [7:0]    ph = 8'd0;
  logic          rv = 1'b0;
  logic          rw = 1'b0;
  logic [AW-1:0] ra = '0;
  logic [31:0]   rwd = '0;

  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          busy;
  logic          sync_error;
  logic [AW:0]   sram_addr;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;

  logic [15:0]   mem_lo = 16'h0;
  logic [15:0]   mem_hi = 16'h0;

  int            tests = 0;
  int            fails = 0;
  int            oe_viol = 0;
  logic          prev_v = 1'b0;
  logic [31:0]   exp_q[$];
  wev_t          wlog[$];

  always #5 clk = ~clk;

  // Tiny SRAM model: the halfword is selected by the address LSB and driven
  // only while output enable is asserted.
  assign sram_dq_in = (!sram_oe_n) ? (sram_addr[0] ? mem_hi : mem_lo) : 16'h0000;

  sram_phase_sequencer #(.RATIO(10), .ADDR_WIDTH(AW)) dut (
    .modified_clock_sram   (clk),
    .reset                 (rst),
    .dcm_locked            (dcm),
    .modified_clock_period (ph),
    .req_valid             (rv),
    .req_write             (rw),
    .req_addr              (ra),
    .req_wdata             (rwd),
    .rsp_valid             (rsp_valid),
    .rsp_rdata             (rsp_rdata),
    .busy                  (busy),
    .sync_error            (sync_error),
    .sram_addr             (sram_addr),
    .sram_ce_n             (sram_ce_n),
    .sram_oe_n             (sram_oe_n),
    .sram_we_n             (sram_we_n),
    .sram_dq_out           (sram_dq_out),
    .sram_dq_oe            (sram_dq_oe),
    .sram_dq_in            (sram_dq_in)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive the phase sampled by the next edge, then return just after it.
  task automatic cyc(input logic [7:0] p);
    ph = p;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_ce_n"},   sram_ce_n,   1'b1);
    chk({tag, "_oe_n"},   sram_oe_n,   1'b1);
    chk({tag, "_we_n"},   sram_we_n,   1'b1);
    chk({tag, "_dq_oe"},  sram_dq_oe,  1'b0);
    chk({tag, "_rsp_v"},  rsp_valid,   1'b0);
    chk({tag, "_busy"},   busy,        1'b0);
    chk({tag, "_syncer"}, sync_error,  1'b0);
    chk({tag, "_addr"},   sram_addr,   19'h0);
    chk({tag, "_dq_out"}, sram_dq_out, 16'h0);
    chk({tag, "_rdata"},  rsp_rdata,   32'h0);
  endtask

  // Monitor: pops the scoreboard on each new completion and records
  // write pulses and bus-contention cycles.
  always @(negedge clk) begin
    if (sram_dq_oe && !sram_oe_n) oe_viol++;
    if (!sram_we_n) wlog.push_back({sram_addr, sram_dq_out});
    if (rsp_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: rsp_valid with rdata %0h, no completion expected", rsp_rdata);
      end else begin
        chk("rsp_rdata_sb", rsp_rdata, exp_q.pop_front());
      end
    end
    prev_v = rsp_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_vals("rst");
    rst = 1'b0;

    // Write 0xDEADBEEF to word 0x12345.
    wlog.delete();
    rv = 1'b1; rw = 1'b1; ra = 18'h12345; rwd = 32'hDEADBEEF;
    exp_q.push_back(32'h0);
    cyc(8'd0);
    rv = 1'b0;
    chk("wr_addr_lo", sram_addr, 19'h2468A);
    chk("wr_dq_lo", sram_dq_out, 16'hBEEF);
    chk("wr_dq_oe", sram_dq_oe, 1'b1);
    chk("wr_ce_n", sram_ce_n, 1'b0);
    chk("wr_busy", busy, 1'b1);
    chk("wr_we_setup", sram_we_n, 1'b1);
    cyc(8'd1); chk("wr_we_lo_pulse", sram_we_n, 1'b0);
    cyc(8'd2); chk("wr_we_lo_end", sram_we_n, 1'b1);
    cyc(8'd3);
    chk("wr_addr_hi", sram_addr, 19'h2468B);
    chk("wr_dq_hi", sram_dq_out, 16'hDEAD);
    cyc(8'd4); chk("wr_we_hi_pulse", sram_we_n, 1'b0);
    cyc(8'd5); chk("wr_we_hi_end", sram_we_n, 1'b1);
    cyc(8'd6);
    chk("wr_done_busy", busy, 1'b0);
    chk("wr_done_ce_n", sram_ce_n, 1'b1);
    chk("wr_done_dq_oe", sram_dq_oe, 1'b0);
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    cyc(8'd7); cyc(8'd8); cyc(8'd9);
    cyc(8'd0);
    chk("wr_rsp_clear", rsp_valid, 1'b0);
    chk("wr_pulse_count", wlog.size(), 2);
    chk("wr_pulse0", wlog[0], {19'h2468A, 16'hBEEF});
    chk("wr_pulse1", wlog[1], {19'h2468B, 16'hDEAD});

    // Read: SRAM returns 0x5678 (low) and 0x1234 (high).
    mem_lo = 16'h5678; mem_hi = 16'h1234;
    rv = 1'b1; rw = 1'b0; ra = 18'h00100;
    exp_q.push_back(32'h12345678);
    cyc(8'd1);   // a request at a nonzero phase is ignored
    chk("rd_ignore_ph1", busy, 1'b0);
    cyc(8'd2); cyc(8'd3); cyc(8'd4); cyc(8'd5);
    cyc(8'd6); cyc(8'd7); cyc(8'd8); cyc(8'd9);
    cyc(8'd0);
    rv = 1'b0;
    chk("rd_addr_lo", sram_addr, 19'h00200);
    chk("rd_oe_n", sram_oe_n, 1'b0);
    chk("rd_dq_oe", sram_dq_oe, 1'b0);
    for (int p = 1; p <= 6; p++) cyc(8'(p));
    chk("rd_rsp_valid6", rsp_valid, 1'b1);
    chk("rd_rdata", rsp_rdata, 32'h12345678);
    chk("rd_oe_release", sram_oe_n, 1'b1);
    cyc(8'd7); chk("rd_rsp_valid7", rsp_valid, 1'b1);
    cyc(8'd8); chk("rd_rsp_valid8", rsp_valid, 1'b1);
    cyc(8'd9); chk("rd_rsp_valid9", rsp_valid, 1'b1);
    cyc(8'd0);
    chk("rd_rsp_clear", rsp_valid, 1'b0);
    chk("rd_rdata_hold", rsp_rdata, 32'h12345678);

    // A request present only at phase 3 starts nothing.
    wlog.delete();
    rw = 1'b1; ra = 18'h00055; rwd = 32'h11112222;
    for (int p = 1; p <= 9; p++) begin
      rv = (p == 3);
      cyc(8'(p));
      if (p == 3) begin
        chk("ph3_busy", busy, 1'b0);
        chk("ph3_ce_n", sram_ce_n, 1'b1);
      end
    end
    rv = 1'b0;
    cyc(8'd0);
    chk("ph3_busy_after", busy, 1'b0);
    chk("ph3_no_we", wlog.size(), 0);

    // The phase jumps 2 to 5 during a write, which must abort with sync_error.
    rv = 1'b1; rw = 1'b1; ra = 18'h00ABC; rwd = 32'h01020304;
    for (int p = 1; p <= 9; p++) cyc(8'(p));
    cyc(8'd0);
    rv = 1'b0;
    cyc(8'd1); cyc(8'd2);
    cyc(8'd5);
    chk("sync_ce_n", sram_ce_n, 1'b1);
    chk("sync_we_n", sram_we_n, 1'b1);
    chk("sync_dq_oe", sram_dq_oe, 1'b0);
    chk("sync_busy", busy, 1'b0);
    chk("sync_flag", sync_error, 1'b1);
    for (int p = 6; p <= 9; p++) cyc(8'(p));
    cyc(8'd0);
    chk("sync_no_rsp", rsp_valid, 1'b0);
    chk("sync_sticky", sync_error, 1'b1);
    rst = 1'b1;
    #1;
    chk("sync_cleared_by_reset", sync_error, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int p = 2; p <= 9; p++) cyc(8'(p));

    // Lock falls at phase 4 of a write. The write aborts without sync_error, and
    // the next read completes.
    wlog.delete();
    rv = 1'b1; rw = 1'b1; ra = 18'h3FFFF; rwd = 32'hCAFEF00D;
    cyc(8'd0);
    rv = 1'b0;
    cyc(8'd1); cyc(8'd2); cyc(8'd3);
    chk("lock_addr_hi", sram_addr, 19'h7FFFF);
    dcm = 1'b0;
    cyc(8'd4);
    chk("lock_ce_n", sram_ce_n, 1'b1);
    chk("lock_busy", busy, 1'b0);
    chk("lock_dq_oe", sram_dq_oe, 1'b0);
    chk("lock_we_n", sram_we_n, 1'b1);
    chk("lock_no_syncerr", sync_error, 1'b0);
    for (int p = 5; p <= 9; p++) cyc(8'(p));
    dcm = 1'b1;
    chk("lock_one_pulse", wlog.size(), 1);
    mem_lo = 16'hAAAA; mem_hi = 16'h5555;
    rv = 1'b1; rw = 1'b0; ra = 18'h00001;
    exp_q.push_back(32'h5555AAAA);
    cyc(8'd0);
    rv = 1'b0;
    for (int p = 1; p <= 6; p++) cyc(8'(p));
    chk("relock_rsp_valid", rsp_valid, 1'b1);
    chk("relock_rdata", rsp_rdata, 32'h5555AAAA);
    cyc(8'd7); cyc(8'd8); cyc(8'd9);

    // Reset pulsed at phase 3 of a read.
    mem_lo = 16'h1111; mem_hi = 16'h2222;
    rv = 1'b1; rw = 1'b0; ra = 18'h00022;
    cyc(8'd0);
    rv = 1'b0;
    cyc(8'd1); cyc(8'd2);
    ph = 8'd3;
    #2 rst = 1'b1;
    #1;
    reset_vals("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int p = 4; p <= 9; p++) cyc(8'(p));
    cyc(8'd0);
    chk("midrst_no_rsp", rsp_valid, 1'b0);
    chk("midrst_idle", busy, 1'b0);

    chk("sb_drained", exp_q.size(), 0);
    chk("dq_oe_vs_oe_n", oe_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
